// File: rtl/feature_frame_loader.sv
`default_nettype none
// ============================================================================
// feature_frame_loader: assembles a byte-serial feature frame for the tree
// classifier, launches it, and returns the class bit or an error response.
// Revision: 1.0
// ============================================================================
module feature_frame_loader #(
   parameter int NUM_FEATURES   = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   input  logic [7:0]                s_data,
   input  logic                      s_last,
   output logic                      s_ready,
   output logic [NUM_FEATURES*8-1:0] feat_packed,
   output logic                      feat_valid,
   output logic                      cls_start,
   input  logic                      cls_done,
   input  logic                      cls_result,
   output logic                      m_valid,
   output logic                      m_result,
   output logic                      m_error,
   input  logic                      m_ready,
   output logic                      busy
);

   localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
   localparam int TC_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);
   localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FILL   = 3'd1,
      S_DRAIN  = 3'd2,
      S_LAUNCH = 3'd3,
      S_WAIT   = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [TC_W-1:0]           tc_q, tc_d;
   logic                      result_q, result_d;
   logic                      error_q, error_d;
   logic                      byte_wr;
   logic [NUM_FEATURES*8-1:0] feat_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         tc_q     <= '0;
         result_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         tc_q     <= tc_d;
         result_q <= result_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tc_d     = tc_q;
      result_d = result_q;
      error_d  = error_q;
      byte_wr  = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FILL;
         S_FILL: begin
            if (s_valid) begin
               byte_wr = 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = s_last ? S_LAUNCH : S_DRAIN;
               end else if (s_last) begin
                  idx_d    = '0;
                  state_d  = S_RESP;
                  error_d  = 1'b1;
                  result_d = 1'b0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (s_valid && s_last) begin
               state_d  = S_RESP;
               error_d  = 1'b1;
               result_d = 1'b0;
            end
         end
         S_LAUNCH: begin
            tc_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A done on the timeout cycle still counts as a real result
            if (cls_done) begin
               result_d = cls_result;
               error_d  = 1'b0;
               state_d  = S_RESP;
            end else if (tc_q == TC_LAST) begin
               result_d = 1'b0;
               error_d  = 1'b1;
               state_d  = S_RESP;
            end else begin
               tc_d = tc_q + TC_W'(1);
            end
         end
         S_RESP: begin
            if (m_ready) begin
               tc_d    = '0;
               state_d = S_FILL;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Per-byte write enables keep feat_packed untouched outside FILL writes
   generate
      for (genvar g = 0; g < NUM_FEATURES; g++) begin : g_byte
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               feat_q[g*8 +: 8] <= 8'h00;
            end else if (byte_wr && (idx_q == IDX_W'(g))) begin
               feat_q[g*8 +: 8] <= s_data;
            end
         end
      end
   endgenerate

   assign s_ready     = (state_q == S_FILL) || (state_q == S_DRAIN);
   assign feat_packed = feat_q;
   assign feat_valid  = (state_q == S_LAUNCH) || (state_q == S_WAIT);
   assign cls_start   = (state_q == S_LAUNCH);
   assign m_valid     = (state_q == S_RESP);
   assign m_result    = result_q;
   assign m_error     = error_q;
   assign busy        = !((state_q == S_FILL) && (idx_q == '0));

endmodule
`default_nettype wire

// File: tb/tb_feature_frame_loader.sv
`default_nettype none
// ============================================================================
// tb_feature_frame_loader: directed bench for the feature frame loader with
// NUM_FEATURES=4 and TIMEOUT_CYCLES=8.
// Revision: 1.0
// ============================================================================
module tb_feature_frame_loader;

   localparam int NF = 4;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid, s_last, s_ready;
   logic [7:0]    s_data;
   logic [NF*8-1:0] feat_packed;
   logic          feat_valid, cls_start, cls_done, cls_result;
   logic          m_valid, m_result, m_error, m_ready, busy;

   int n_chk  = 0;
   int n_pass = 0;

   feature_frame_loader #(
      .NUM_FEATURES   (NF),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .feat_packed (feat_packed),
      .feat_valid  (feat_valid),
      .cls_start   (cls_start),
      .cls_done    (cls_done),
      .cls_result  (cls_result),
      .m_valid     (m_valid),
      .m_result    (m_result),
      .m_error     (m_error),
      .m_ready     (m_ready),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      check("s_ready_before_byte", 32'(s_ready), 32'd1);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'h00;
   endtask

   task automatic respond();
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_s_ready"},    32'(s_ready),    32'd0);
      check({tag, "_feat"},       feat_packed,     32'h0);
      check({tag, "_feat_valid"}, 32'(feat_valid), 32'd0);
      check({tag, "_cls_start"},  32'(cls_start),  32'd0);
      check({tag, "_m_valid"},    32'(m_valid),    32'd0);
      check({tag, "_m_result"},   32'(m_result),   32'd0);
      check({tag, "_m_error"},    32'(m_error),    32'd0);
      check({tag, "_busy"},       32'(busy),       32'd1);
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
      cls_done = 1'b0; cls_result = 1'b0; m_ready = 1'b0;
      #12;
      check_reset_outs("reset");
      @(negedge clk);
      rst = 1'b0;
      check("idle_s_ready", 32'(s_ready), 32'd0);
      step();
      check("fill_s_ready", 32'(s_ready), 32'd1);
      check("fill_idle_busy", 32'(busy), 32'd0);

      // Normal frame, result 1 three cycles after launch
      send(8'd10, 1'b0);
      check("busy_mid_frame", 32'(busy), 32'd1);
      send(8'd20, 1'b0);
      send(8'd30, 1'b0);
      send(8'd40, 1'b1);
      check("launch_cls_start", 32'(cls_start), 32'd1);
      check("launch_feat_valid", 32'(feat_valid), 32'd1);
      check("launch_feat", feat_packed, 32'h281E140A);
      check("launch_s_ready", 32'(s_ready), 32'd0);
      step();
      check("wait_cls_start", 32'(cls_start), 32'd0);
      check("wait_feat_valid", 32'(feat_valid), 32'd1);
      step();
      step();
      cls_done = 1'b1; cls_result = 1'b1;
      step();
      cls_done = 1'b0; cls_result = 1'b0;
      check("done_m_valid", 32'(m_valid), 32'd1);
      check("done_m_result", 32'(m_result), 32'd1);
      check("done_m_error", 32'(m_error), 32'd0);
      respond();
      check("after_resp_m_valid", 32'(m_valid), 32'd0);
      check("after_resp_s_ready", 32'(s_ready), 32'd1);

      // Short frame
      send(8'd1, 1'b0);
      send(8'd2, 1'b0);
      send(8'd3, 1'b1);
      check("short_m_valid", 32'(m_valid), 32'd1);
      check("short_m_error", 32'(m_error), 32'd1);
      check("short_m_result", 32'(m_result), 32'd0);
      check("short_cls_start", 32'(cls_start), 32'd0);
      check("short_feat", feat_packed, 32'h28030201);
      respond();

      // Next frame classifies normally
      send(8'd5, 1'b0);
      send(8'd6, 1'b0);
      send(8'd7, 1'b0);
      send(8'd8, 1'b1);
      check("frame2_cls_start", 32'(cls_start), 32'd1);
      check("frame2_feat", feat_packed, 32'h08070605);
      step();
      cls_done = 1'b1; cls_result = 1'b1;
      step();
      cls_done = 1'b0; cls_result = 1'b0;
      check("frame2_m_valid", 32'(m_valid), 32'd1);
      check("frame2_m_error", 32'(m_error), 32'd0);

      // Response held against a stalled consumer with stream noise
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = 8'($urandom_range(0, 255));
         s_last  = 1'($urandom_range(0, 1));
         step();
         check("hold_s_ready", 32'(s_ready), 32'd0);
         check("hold_m_valid", 32'(m_valid), 32'd1);
         check("hold_m_result", 32'(m_result), 32'd1);
         check("hold_m_error", 32'(m_error), 32'd0);
         check("hold_feat", feat_packed, 32'h08070605);
      end
      s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
      respond();
      check("hold_release_s_ready", 32'(s_ready), 32'd1);
      check("hold_release_busy", 32'(busy), 32'd0);

      // Long frame
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b0);
      check("long_drain_m_valid", 32'(m_valid), 32'd0);
      check("long_drain_cls_start", 32'(cls_start), 32'd0);
      send(8'h55, 1'b0);
      send(8'h66, 1'b1);
      check("long_m_valid", 32'(m_valid), 32'd1);
      check("long_m_error", 32'(m_error), 32'd1);
      check("long_cls_start", 32'(cls_start), 32'd0);
      check("long_feat", feat_packed, 32'h44332211);
      respond();

      // Timeout; a done during LAUNCH must be ignored
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b0);
      send(8'hA3, 1'b0);
      send(8'hA4, 1'b1);
      cls_done = 1'b1; cls_result = 1'b1;
      step();
      cls_done = 1'b0; cls_result = 1'b0;
      check("launch_done_ignored", 32'(m_valid), 32'd0);
      for (int i = 0; i < TO - 1; i++) step();
      check("timeout_not_yet", 32'(m_valid), 32'd0);
      step();
      check("timeout_m_valid", 32'(m_valid), 32'd1);
      check("timeout_m_error", 32'(m_error), 32'd1);
      check("timeout_m_result", 32'(m_result), 32'd0);
      respond();

      // Done coincident with the timeout cycle
      send(8'hB1, 1'b0);
      send(8'hB2, 1'b0);
      send(8'hB3, 1'b0);
      send(8'hB4, 1'b1);
      step();
      for (int i = 0; i < TO - 1; i++) step();
      cls_done = 1'b1; cls_result = 1'b1;
      step();
      cls_done = 1'b0; cls_result = 1'b0;
      check("coinc_m_valid", 32'(m_valid), 32'd1);
      check("coinc_m_error", 32'(m_error), 32'd0);
      check("coinc_m_result", 32'(m_result), 32'd1);
      respond();

      // Asynchronous reset while waiting for the classifier
      send(8'hC1, 1'b0);
      send(8'hC2, 1'b0);
      send(8'hC3, 1'b0);
      send(8'hC4, 1'b1);
      step();
      step();
      #2 rst = 1'b1;
      #1 check_reset_outs("async_rst");
      @(negedge clk);
      rst = 1'b0;
      check("post_rst_idle_s_ready", 32'(s_ready), 32'd0);
      cls_done = 1'b1; cls_result = 1'b1;
      step();
      cls_done = 1'b0; cls_result = 1'b0;
      check("post_rst_s_ready", 32'(s_ready), 32'd1);
      check("post_rst_m_valid", 32'(m_valid), 32'd0);
      cls_done = 1'b1;
      step();
      cls_done = 1'b0;
      check("fill_done_ignored", 32'(m_valid), 32'd0);
      check("fill_done_feat_valid", 32'(feat_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
